// File: rtl/register_bank_loader.sv
// register_bank_loader
//    Feeds the 8 x 8-bit systolic register bank from a valid/ready byte stream.
//    Each accepted byte goes straight to the bank's sample register (bank_enable,
//    bank_data).  One cycle later the matching one-hot row select is driven, so
//    the row captures the sampled byte.  Once every row is committed, bank_valid
//    is raised and further input is held off until the consumer signals consume.
//
// Ports
//    clk          single clock, posedge
//    reset        synchronous, active-high
//    start        begin a fill (IDLE, or FULL together with consume)
//    s_valid      input byte valid
//    s_data       input byte
//    s_ready      byte accepted this cycle when s_valid is also high
//    consume      downstream has taken the bank contents
//    bank_enable  bank samples bank_data at this edge
//    bank_data    byte to the bank (zero when no beat is accepted)
//    bank_select  one-hot row select to the bank, or zero
//    bank_valid   all rows written and stable
//    busy         loader is not idle
//    rows_loaded  rows committed to the bank so far
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start, input held off
// FILL  | accepting bytes, one row per accepted beat
// FLUSH | last row select is on the bank, no input taken
// FULL  | bank complete and valid, waiting for consume

module register_bank_loader #(
   parameter int DATA_WIDTH = 8,
   parameter int BANK_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          s_valid,
   input  logic [DATA_WIDTH-1:0]         s_data,
   output logic                          s_ready,
   input  logic                          consume,
   output logic                          bank_enable,
   output logic [DATA_WIDTH-1:0]         bank_data,
   output logic [BANK_DEPTH-1:0]         bank_select,
   output logic                          bank_valid,
   output logic                          busy,
   output logic [$clog2(BANK_DEPTH):0]   rows_loaded
);

   localparam int IDX_W = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
   localparam int CNT_W = $clog2(BANK_DEPTH) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BANK_DEPTH - 1);
   localparam logic [BANK_DEPTH-1:0] ONE_HOT_0 = {{(BANK_DEPTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_FLUSH,
      S_FULL
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [IDX_W-1:0]       index;
   logic [IDX_W-1:0]       index_nxt;
   logic [BANK_DEPTH-1:0]  select_nxt;
   logic [CNT_W-1:0]       rows_nxt;
   logic                   valid_nxt;
   logic                   accepted;

   always_comb begin
      state_nxt   = state;
      index_nxt   = index;
      select_nxt  = '0;
      valid_nxt   = bank_valid;
      // A row is committed on the edge after its select is driven.
      rows_nxt    = rows_loaded + {{(CNT_W-1){1'b0}}, |bank_select};

      // Gating with reset keeps the bank from sampling while a reset is pending.
      s_ready     = (state == S_FILL) && !reset;
      accepted    = s_valid && s_ready;
      bank_enable = accepted;
      bank_data   = accepted ? s_data : '0;
      busy        = (state != S_IDLE);

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_FILL;
               index_nxt = '0;
               rows_nxt  = '0;
            end
         end
         S_FILL: begin
            if (accepted) begin
               select_nxt = ONE_HOT_0 << index;
               index_nxt  = index + IDX_W'(1);
               if (index == LAST_IDX) begin
                  state_nxt = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            state_nxt = S_FULL;
            valid_nxt = 1'b1;
         end
         S_FULL: begin
            if (consume) begin
               valid_nxt = 1'b0;
               if (start) begin
                  state_nxt = S_FILL;
                  index_nxt = '0;
                  rows_nxt  = '0;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         index       <= '0;
         bank_select <= '0;
         rows_loaded <= '0;
         bank_valid  <= 1'b0;
      end else begin
         state       <= state_nxt;
         index       <= index_nxt;
         bank_select <= select_nxt;
         rows_loaded <= rows_nxt;
         bank_valid  <= valid_nxt;
      end
   end

endmodule
